multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS31 CPU. It sequences fetch, decode, execute, memory and write-back for one instruction at a time.
- Input is the 32-bit one-hot instruction class from the instruction decoder, driven from the IR contents.
- Outputs are the datapath enables and mux selects, plus a memory request/acknowledge handshake, trap detection and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- WAIT_MAX, 255, maximum cycles to wait for imem_ack/dmem_ack before trapping.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- choose  in  32  one-hot class. Bits 0..16: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr. Bits 17..30: addi, addiu, andi, ori, xori, lw, sw, beq, bne, slti, sltiu, lui, j, jal. Bit 31 unused.
- alu_zero  in  1  ALU result == 0.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write (valid with dmem_req).
- ir_we  out  1  load IR.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs.
- rf_we  out  1  register file write.
- rf_wsel  out  2  0 = rd, 1 = rt, 2 = r31.
- rf_dsel  out  2  0 = ALU, 1 = memory, 2 = pc+4.
- alu_op  out  4  0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 lui.
- alu_bsel  out  1  0 = rt, 1 = immediate.
- imm_sext  out  1  1 = sign-extend imm16, 0 = zero-extend.
- shamt_sel  out  1  1 = shift amount from rs (variable shifts), 0 = from shamt.
- illegal  out  1  sticky trap, illegal instruction class.
- timeout  out  1  sticky trap, handshake timeout.
- state  out  3  current state.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- States: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 7.
- Reset (async, rst_n = 0): state = IDLE; op_q, wait counter, instr_cnt, illegal and timeout cleared; all outputs 0.
- IDLE: all enables 0. Goes to FETCH on the next clk.
- Outputs are decoded combinationally from state and op_q, the registered copy of choose. Enables are 0 in any state not listed below.
- FETCH:
  - imem_req = 1 until imem_ack.
  - In the ack cycle: ir_we = 1, then go to DECODE.
- DECODE:
  - Captures choose into op_q.
  - If choose[30:0] is not exactly one-hot (all-zero, multi-hot, x/z), go to TRAP and set illegal. Otherwise go to EXEC.
- EXEC (alu_op, alu_bsel, imm_sext, shamt_sel valid from op_q):
  - beq/bne: alu_op = sub, pc_we = 1. pc_src = 1 if (beq & alu_zero) | (bne & ~alu_zero), else 0. Retire, go to FETCH.
  - j: pc_we = 1, pc_src = 2. Retire, go to FETCH.
  - jal: same as j, plus rf_we = 1, rf_wsel = 2, rf_dsel = 2.
  - jr: pc_we = 1, pc_src = 3. Retire, go to FETCH.
  - lw/sw: alu_op = addu, alu_bsel = 1, imm_sext = 1. Go to MEM.
  - All others: go to WB.
  - Immediate extension: sign-extend for addi, addiu, slti, sltiu. Zero-extend for andi, ori, xori.
- MEM:
  - Keeps the EXEC address controls. dmem_req = 1 until dmem_ack; dmem_we = 1 for sw.
  - On ack, sw: pc_we = 1, pc_src = 0, retire, go to FETCH.
  - On ack, lw: go to WB.
- WB:
  - rf_we = 1 and pc_we = 1 (pc_src = 0). Retire, go to FETCH.
  - rf_wsel = 0 for R-type, 1 for I-type and lw.
  - rf_dsel = 1 for lw, else 0.
  - ALU controls are held from EXEC.
- Retire: instr_cnt += 1 in the retiring cycle. Wraps modulo 2^CNT_W.
- Handshake timeout:
  - The wait counter clears on state entry and increments each cycle FETCH/MEM waits without ack.
  - When it reaches WAIT_MAX with no ack, go to TRAP and set timeout.
  - An ack arriving in the same cycle the count reaches WAIT_MAX takes priority (no trap).
- TRAP: all enables 0, state held until reset. illegal and timeout stay set until reset.
- Reset mid-operation: any state returns to IDLE immediately; pending requests drop in the same cycle with no write enables. In-flight lw/sw is abandoned.

Test Plan:
- Reset release, imem_ack tied 1: state 0->1->2->3. ir_we pulses in cycle 1 after IDLE; all outputs 0 during reset.
- addu (choose = 0x2), acks immediate: FETCH, DECODE, EXEC, WB, 4 cycles after IDLE. WB shows rf_we = 1, rf_wsel = 0, rf_dsel = 0, alu_op = 1, pc_src = 0; instr_cnt = 1.
- lw (choose = 0x0040_0000), dmem_ack after 3 cycles: dmem_req held 4 cycles, dmem_we = 0. WB shows rf_wsel = 1, rf_dsel = 1.
- sw (choose = 0x0080_0000), dmem_ack immediate: dmem_req = 1 and dmem_we = 1 for one cycle, then back to FETCH with pc_we = 1, pc_src = 0; no WB visit.
- beq (choose = 0x0100_0000): alu_zero = 1 gives pc_src = 1; alu_zero = 0 gives pc_src = 0. bne gives the inverse. jal (choose = 0x4000_0000) gives pc_src = 2, rf_we = 1, rf_wsel = 2, rf_dsel = 2.
- Trap and reset cases:
  - choose = 0 at DECODE: state 7, illegal = 1, counter frozen.
  - imem_ack held 0 for 255 cycles: timeout = 1.
  - rst_n pulse mid-MEM: state 0, dmem_req = 0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS31 CPU: fetch, decode, execute,
// memory and write-back for one instruction at a time, with trap detection.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      choose,
  input  logic             alu_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic [1:0]       rf_dsel,
  output logic [3:0]       alu_op,
  output logic             alu_bsel,
  output logic             imm_sext,
  output logic             shamt_sel,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [30:0]       op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              retire;
  logic              waiting, wait_hit, alu_active;
  logic [3:0]        alu_code;
  logic              unused_bit31;

  // Bit 31 of the class vector carries no instruction.
  assign unused_bit31 = choose[31];

  logic is_rtype, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_imm_alu, is_varshift, uses_sext;
  assign is_rtype    = |op_q[15:0];
  assign is_jr       = op_q[16];
  assign is_lw       = op_q[22];
  assign is_sw       = op_q[23];
  assign is_beq      = op_q[24];
  assign is_bne      = op_q[25];
  assign is_j        = op_q[29];
  assign is_jal      = op_q[30];
  assign is_imm_alu  = (|op_q[21:17]) | (|op_q[28:26]);
  assign is_varshift = |op_q[15:13];
  assign uses_sext   = op_q[17] | op_q[18] | op_q[26] | op_q[27] | is_lw | is_sw;

  always_comb begin
    alu_code = 4'd0;
    if (op_q[1] | op_q[18] | is_lw | is_sw) alu_code = 4'd1;
    if (op_q[2] | is_beq | is_bne)          alu_code = 4'd2;
    if (op_q[3])                            alu_code = 4'd3;
    if (op_q[4] | op_q[19])                 alu_code = 4'd4;
    if (op_q[5] | op_q[20])                 alu_code = 4'd5;
    if (op_q[6] | op_q[21])                 alu_code = 4'd6;
    if (op_q[7])                            alu_code = 4'd7;
    if (op_q[8] | op_q[26])                 alu_code = 4'd8;
    if (op_q[9] | op_q[27])                 alu_code = 4'd9;
    if (op_q[10] | op_q[13])                alu_code = 4'd10;
    if (op_q[11] | op_q[14])                alu_code = 4'd11;
    if (op_q[12] | op_q[15])                alu_code = 4'd12;
    if (op_q[28])                           alu_code = 4'd13;
  end

  assign alu_active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
  assign waiting    = ((state_q == S_FETCH) & ~imem_ack) | ((state_q == S_MEM) & ~dmem_ack);
  // An ack in the last allowed cycle clears waiting, so it beats the trap.
  assign wait_hit   = waiting & (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    wait_d    = (waiting & ~wait_hit) ? wait_q + WAIT_W'(1) : '0;
    if (wait_hit) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  if (imem_ack) state_d = S_DECODE;
        S_DECODE: begin
          op_d = choose[30:0];
          if ($onehot(choose[30:0])) begin
            state_d = S_EXEC;
          end else begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_beq | is_bne | is_j | is_jal | is_jr) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else if (is_lw | is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_sw) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    rf_we     = 1'b0;
    rf_wsel   = 2'd0;
    rf_dsel   = 2'd0;
    alu_op    = 4'd0;
    alu_bsel  = 1'b0;
    imm_sext  = 1'b0;
    shamt_sel = 1'b0;
    if (alu_active) begin
      alu_op    = alu_code;
      alu_bsel  = is_imm_alu | is_lw | is_sw;
      imm_sext  = uses_sext;
      shamt_sel = is_varshift;
    end
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC: begin
        if (is_beq | is_bne) begin
          pc_we  = 1'b1;
          pc_src = ((is_beq & alu_zero) | (is_bne & ~alu_zero)) ? 2'd1 : 2'd0;
        end
        if (is_j | is_jal) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
        if (is_jal) begin
          rf_we   = 1'b1;
          rf_wsel = 2'd2;
          rf_dsel = 2'd2;
        end
        if (is_jr) begin
          pc_we  = 1'b1;
          pc_src = 2'd3;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        pc_we    = is_sw & dmem_ack;
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        rf_wsel = is_rtype ? 2'd0 : 2'd1;
        rf_dsel = is_lw ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction class into the expected per-cycle control words and counter.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  localparam int CW       = 4;
  localparam int WAIT_MAX = 255;
  localparam int W        = CW + 24;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic [1:0] rf_wsel, rf_dsel;
    logic [3:0] alu_op;
    logic       alu_bsel, imm_sext, shamt_sel, illegal, timeout;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   choose = '0;
  logic          alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic [1:0]    pc_src, rf_wsel, rf_dsel;
  logic [3:0]    alu_op;
  logic          alu_bsel, imm_sext, shamt_sel, illegal, timeout;
  logic [2:0]    state;
  logic [CW-1:0] instr_cnt;

  multicycle_ctrl #(.CNT_W(CW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .choose(choose), .alu_zero(alu_zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_dsel(rf_dsel),
    .alu_op(alu_op), .alu_bsel(alu_bsel), .imm_sext(imm_sext),
    .shamt_sel(shamt_sel), .illegal(illegal), .timeout(timeout),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  logic [34:0]   stim_q[$];
  logic [CW-1:0] m_cnt = '0;
  logic          m_ill = 1'b0, m_to = 1'b0;
  // ALU operation per instruction class, straight from the opcode table.
  int alu_tab[31] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 10, 11, 12,
                      0, 0, 1, 4, 5, 6, 1, 1, 2, 2, 8, 9, 13, 0, 0};

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t c = '0;
    c.st = st;
    c.illegal = m_ill;
    c.timeout = m_to;
    return c;
  endfunction

  function automatic void push(input ctl_t c, input logic [31:0] ch, input logic ia,
                               input logic da, input logic z);
    exp_q.push_back({m_cnt, c});
    stim_q.push_back({ch, ia, da, z});
  endfunction

  function automatic void model_trap(input logic ill, input logic to);
    m_ill = m_ill | ill;
    m_to  = m_to | to;
    for (int k = 0; k < 4; k++) push(base(3'd7), $urandom(), rb(), rb(), rb());
  endfunction

  function automatic void model_instr(input int idx, input int fw, input int mw, input logic zero);
    ctl_t c, a;
    logic rtype = (idx <= 15);
    logic lw = (idx == 22);
    logic sw = (idx == 23);
    a = base(3'd0);
    a.alu_op    = 4'(alu_tab[idx]);
    a.alu_bsel  = (idx >= 17 && idx <= 23) || (idx >= 26 && idx <= 28);
    a.imm_sext  = idx inside {17, 18, 22, 23, 26, 27};
    a.shamt_sel = idx inside {13, 14, 15};
    for (int k = 0; k < fw && k < WAIT_MAX; k++) begin
      c = base(3'd1); c.imem_req = 1'b1;
      push(c, $urandom(), 1'b0, rb(), rb());
    end
    if (fw >= WAIT_MAX) begin model_trap(1'b0, 1'b1); return; end
    c = base(3'd1); c.imem_req = 1'b1; c.ir_we = 1'b1;
    push(c, $urandom(), 1'b1, rb(), rb());
    push(base(3'd2), 32'd1 << idx, rb(), rb(), rb());
    c = a; c.st = 3'd3;
    if (idx == 24 || idx == 25 || idx == 29 || idx == 30 || idx == 16) begin
      c.pc_we = 1'b1;
      if (idx == 24 || idx == 25) c.pc_src = ((idx == 24) == zero) ? 2'd1 : 2'd0;
      else if (idx == 16) c.pc_src = 2'd3;
      else c.pc_src = 2'd2;
      if (idx == 30) begin c.rf_we = 1'b1; c.rf_wsel = 2'd2; c.rf_dsel = 2'd2; end
      push(c, $urandom(), rb(), rb(), zero);
      m_cnt++;
      return;
    end
    push(c, $urandom(), rb(), rb(), zero);
    if (lw || sw) begin
      for (int k = 0; k < mw && k < WAIT_MAX; k++) begin
        c = a; c.st = 3'd4; c.dmem_req = 1'b1; c.dmem_we = sw;
        push(c, $urandom(), rb(), 1'b0, rb());
      end
      if (mw >= WAIT_MAX) begin model_trap(1'b0, 1'b1); return; end
      c = a; c.st = 3'd4; c.dmem_req = 1'b1; c.dmem_we = sw; c.pc_we = sw;
      push(c, $urandom(), rb(), 1'b1, rb());
      if (sw) begin m_cnt++; return; end
    end
    c = a; c.st = 3'd5; c.rf_we = 1'b1; c.pc_we = 1'b1;
    c.rf_wsel = rtype ? 2'd0 : 2'd1;
    c.rf_dsel = lw ? 2'd1 : 2'd0;
    push(c, $urandom(), rb(), rb(), rb());
    m_cnt++;
  endfunction

  function automatic void model_illegal(input logic [31:0] ch);
    ctl_t c;
    c = base(3'd1); c.imem_req = 1'b1; c.ir_we = 1'b1;
    push(c, $urandom(), 1'b1, rb(), rb());
    push(base(3'd2), ch, rb(), rb(), rb());
    model_trap(1'b1, 1'b0);
  endfunction

  function automatic logic [W-1:0] observe();
    ctl_t c;
    c.st = state; c.imem_req = imem_req; c.dmem_req = dmem_req; c.dmem_we = dmem_we;
    c.ir_we = ir_we; c.pc_we = pc_we; c.pc_src = pc_src; c.rf_we = rf_we;
    c.rf_wsel = rf_wsel; c.rf_dsel = rf_dsel; c.alu_op = alu_op; c.alu_bsel = alu_bsel;
    c.imm_sext = imm_sext; c.shamt_sel = shamt_sel; c.illegal = illegal; c.timeout = timeout;
    return {instr_cnt, c};
  endfunction

  // Called at posedge+1; applies one stimulus per cycle, samples at negedge.
  task automatic apply_stim(input int n);
    logic [34:0] s;
    for (int k = 0; k < n && stim_q.size() > 0; k++) begin
      s = stim_q.pop_front();
      {choose, imem_ack, dmem_ack, alu_zero} = s;
      @(negedge clk);
      obs_q.push_back(observe());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    choose = $urandom(); imem_ack = 1'b1; dmem_ack = 1'b1; alu_zero = rb();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_cnt = '0; m_ill = 1'b0; m_to = 1'b0;
    push(base(3'd0), $urandom(), rb(), rb(), rb());
  endtask

  task automatic test_reset();
    logic [W-1:0] o, e;
    imem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (observe() !== '0) begin
        errors++; $display("FAIL reset_outputs got %h expected 0", observe());
      end
      choose = $urandom(); dmem_ack = rb(); alu_zero = rb();
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(base(3'd0), $urandom(), 1'b1, rb(), rb());
    model_instr(1, 0, 0, 1'b0);
    apply_stim(stim_q.size());
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_addu cycle %0d got %h expected %h", k, o, e); end
    end
    checks++;
    if (instr_cnt !== CW'(1)) begin errors++; $display("FAIL addu_retire got %0d expected 1", instr_cnt); end
  endtask

  task automatic test_all_classes();
    logic [W-1:0] o, e;
    for (int idx = 0; idx < 31; idx++)
      model_instr(idx, $urandom_range(2, 0), $urandom_range(2, 0), rb());
    apply_stim(stim_q.size());
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL all_classes cycle %0d got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_lw_sw();
    logic [W-1:0] o, e;
    model_instr(22, 0, 3, 1'b0);
    model_instr(23, 0, 0, 1'b0);
    model_instr(23, 2, 5, 1'b1);
    apply_stim(stim_q.size());
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lw_sw cycle %0d got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_branches();
    logic [W-1:0] o, e;
    model_instr(24, 0, 0, 1'b1);
    model_instr(24, 0, 0, 1'b0);
    model_instr(25, 0, 0, 1'b1);
    model_instr(25, 0, 0, 1'b0);
    model_instr(29, 1, 0, rb());
    model_instr(30, 0, 0, rb());
    model_instr(16, 0, 0, rb());
    apply_stim(stim_q.size());
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL branches cycle %0d got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] o, e;
    for (int n = 0; n < 40; n++)
      model_instr($urandom_range(30, 0), $urandom_range(3, 0), $urandom_range(3, 0), rb());
    apply_stim(stim_q.size());
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back cycle %0d got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] o, e;
    logic [31:0] bad[3] = '{32'h0000_0000, 32'h0000_0003, 32'h8000_0000};
    for (int b = 0; b < 3; b++) begin
      reset_dut();
      model_instr(1, 0, 0, 1'b0);
      model_illegal(bad[b]);
      apply_stim(stim_q.size());
      for (int k = 0; obs_q.size() > 0; k++) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL illegal_%0d cycle %0d got %h expected %h", b, k, o, e); end
      end
      checks++;
      if ({state, illegal, timeout, instr_cnt} !== {3'd7, 1'b1, 1'b0, CW'(1)}) begin
        errors++;
        $display("FAIL illegal_sticky_%0d got st=%0d ill=%b to=%b cnt=%0d expected st=7 ill=1 to=0 cnt=1",
                 b, state, illegal, timeout, instr_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] o, e;
    for (int m = 0; m < 2; m++) begin
      reset_dut();
      if (m == 0) begin
        model_instr(1, WAIT_MAX - 1, 0, 1'b0);
        model_instr(5, WAIT_MAX, 0, 1'b0);
      end else begin
        model_instr(22, 0, WAIT_MAX - 1, 1'b0);
        model_instr(23, 0, WAIT_MAX, 1'b0);
      end
      apply_stim(stim_q.size());
      for (int k = 0; obs_q.size() > 0; k++) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL timeout_%0d cycle %0d got %h expected %h", m, k, o, e); end
      end
      checks++;
      if ({state, timeout, illegal} !== {3'd7, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL timeout_sticky_%0d got st=%0d to=%b ill=%b expected st=7 to=1 ill=0",
                 m, state, timeout, illegal);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [W-1:0] o, e;
    reset_dut();
    model_instr(1, 0, 0, 1'b0);
    model_instr(22, 0, 50, 1'b0);
    apply_stim(9);
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_mem_pre cycle %0d got %h expected %h", k, o, e); end
    end
    exp_q.delete();
    stim_q.delete();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if ({state, dmem_req} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL mid_mem_inflight got st=%0d req=%b expected st=4 req=1", state, dmem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (observe() !== '0) begin
      errors++; $display("FAIL mid_mem_async_reset got %h expected 0", observe());
    end
    reset_dut();
    model_instr(23, 1, 1, 1'b0);
    apply_stim(stim_q.size());
    for (int k = 0; obs_q.size() > 0; k++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_mem_recover cycle %0d got %h expected %h", k, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_all_classes();
    test_lw_sw();
    test_branches();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
